uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter with an internal TX FIFO; successor to the fixed 8N1, single-byte uart_tx.
//  Adds configurable data bits, parity and stop bits, plus buffering so software and bench drivers can burst words.
//  Sits between the core UART peripheral (or a bench driver) and the txd pin; the serial frame format matches uart_rx.
// PARAMETERS
//  clk_freq    50_000_000  input clock frequency, Hz
//  baud_ratio  115200      baud rate; DIV = (clk_freq + baud_ratio/2) / baud_ratio clocks per bit (434 at defaults)
//  DATA_BITS   8           data bits per frame, legal 5..8, sent LSB first
//  DEPTH       16          FIFO entries; power of 2, >= 2
//  PARITY      0           0 = none, 1 = odd, 2 = even
//  STOP_BITS   1           stop bits per frame, 1 or 2
// PORTS
//  clk     in   1                 single clock; all logic on its rising edge
//  rst_n   in   1                 asynchronous, active-low reset
//  tdata   in   DATA_BITS         word to enqueue
//  tvld    in   1                 enqueue request; accepted on a clock edge where tvld && trdy
//  trdy    out  1                 FIFO not full
//  clr     in   1                 synchronous flush of FIFO and ovf
//  txd     out  1                 serial output, idle high
//  busy    out  1                 frame in progress OR FIFO non-empty
//  level   out  $clog2(DEPTH)+1   FIFO occupancy, 0..DEPTH
//  ovf     out  1                 sticky: tvld seen while trdy=0
// BEHAVIOUR
//  Reset (async): txd=1, trdy=1, busy=0, level=0, ovf=0, FSM=IDLE, baud counter=0, FIFO pointers=0.
//  FIFO: registered wr/rd pointers plus count; no bypass path. A push is accepted only if count<DEPTH at that edge;
//   trdy=0 when full even if a pop happens in the same cycle. Push and pop in the same cycle leave level unchanged.
//  Overflow: tvld=1 with trdy=0 drops the word and sets ovf; ovf clears only on clr or reset.
//  clr: on the next edge FIFO empties (level=0) and ovf clears. A frame already in progress completes unchanged.
//   clr and tvld in the same cycle: clr wins; the word is dropped and ovf is not set.
//  FSM: IDLE -> START -> DATA -> [PAR] -> STOP -> IDLE/START.
//   IDLE: if count>0, pop the head into the shift register, go to START, and drive txd=0 at the next edge.
//    First start-bit edge = 2 edges after the push edge when the FIFO was empty.
//   START: 1 bit time at txd=0.
//   DATA: DATA_BITS bit times, LSB first. Bits above DATA_BITS are not present (width = DATA_BITS).
//   PAR: only if PARITY!=0; even: bit = ^data; odd: bit = ~^data. 1 bit time.
//   STOP: STOP_BITS bit times at txd=1. At the end of the last stop bit: if count>0, pop and enter START directly
//    (no idle gap; frames back-to-back); else IDLE.
//  Bit time: exactly DIV clocks. The baud counter runs 0..DIV-1, resets on each state entry from IDLE, and wraps
//   without drift.
//  Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV clocks.
//  txd is driven from a flop (glitch-free); it is 1 whenever FSM=IDLE.
//  busy = (FSM!=IDLE) | (count!=0); it falls on the edge ending the final stop bit of the last queued word.
//  Reset mid-frame: txd returns to 1 immediately (async); the FIFO contents are lost.
// TESTING
//  1 Defaults, push 0x55 once -> txd low 2 edges after push, then 0,1,0,1,0,1,0,1,0,1 (LSB first) then stop=1;
//    each bit 434 clk; busy high for 4340 clk.
//  2 PARITY=2, push 0x07 -> parity bit 1; PARITY=1, push 0x07 -> parity bit 0; frame = 11*DIV clk.
//  3 DEPTH=16, 17 pushes on consecutive clocks from empty -> first word starts transmitting (popped), so 17 accepted;
//    an 18th push -> trdy=0, ovf=1, level=16; clr -> level=0, ovf=0 on the next edge, current frame finishes.
//  4 STOP_BITS=2, push 0xA3, 0x3C back-to-back -> second start bit immediately after 2 stop bits;
//    total 22*DIV clk; uart_rx loopback reports 0xA3, 0x3C.
//  5 DATA_BITS=5, push 0x1F with tvld held 1 for 3 clocks while FIFO full -> ovf=1 and level unchanged;
//    after drain, 7*DIV frame with data 11111.
//  6 Deassert rst_n mid-DATA of 0x55 -> txd=1, level=0, busy=0 asynchronously;
//    after release, push 0x41 -> clean frame, rx reads 'A'.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a TX FIFO in front of it: configurable data bits, parity and stop bits.
// Words are queued through a tvld/trdy handshake and sent back-to-back on txd, which idles high.
module uart_tx_fifo #(
    parameter int clk_freq   = 50_000_000,
    parameter int baud_ratio = 115200,
    parameter int DATA_BITS  = 8,
    parameter int DEPTH      = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_BITS-1:0]       tdata,
    input  logic                       tvld,
    output logic                       trdy,
    input  logic                       clr,
    output logic                       txd,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf
);

    localparam int DIV = (clk_freq + baud_ratio / 2) / baud_ratio;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int BW  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // Parity over the frame's data bits: even = ^d, odd = ~^d.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        if (PARITY == 2) begin
            parity_bit = ^d;
        end else begin
            parity_bit = ~^d;
        end
    endfunction

    logic [DATA_BITS-1:0] mem_r [DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [LW-1:0]        count_r;
    logic                 ovf_r;

    state_t               state_r;
    state_t               state_s;
    logic [CW-1:0]        baud_r;
    logic [CW-1:0]        baud_s;
    logic [BW-1:0]        bit_r;
    logic [BW-1:0]        bit_s;
    logic [DATA_BITS-1:0] data_r;
    logic [DATA_BITS-1:0] data_s;
    logic                 txd_r;
    logic                 txd_s;

    logic                 trdy_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 can_pop_s;
    logic                 tick_s;

    // A pop never coincides with a flush, so clr cannot launch a new frame.
    assign trdy_s    = (count_r != LW'(DEPTH));
    assign push_s    = tvld && trdy_s && !clr;
    assign can_pop_s = (count_r != {LW{1'b0}}) && !clr;
    assign tick_s    = (baud_r == CW'(DIV - 1));

    assign trdy  = trdy_s;
    assign level = count_r;
    assign ovf   = ovf_r;
    assign txd   = txd_r;
    assign busy  = (state_r != ST_IDLE) || (count_r != {LW{1'b0}});

    // FIFO storage; contents need no reset because count_r gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= tdata;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
            ovf_r    <= 1'b0;
        end else if (clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            if (tvld && !trdy_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Frame sequencer state, baud counter, bit index, held word and txd flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            baud_r  <= {CW{1'b0}};
            bit_r   <= {BW{1'b0}};
            data_r  <= {DATA_BITS{1'b0}};
            txd_r   <= 1'b1;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            data_r  <= data_s;
            txd_r   <= txd_s;
        end
    end

    // Next-state logic; txd follows the current state one clock later, so every bit is still DIV clocks.
    always_comb begin
        state_s = state_r;
        baud_s  = tick_s ? {CW{1'b0}} : baud_r + 1'b1;
        bit_s   = bit_r;
        data_s  = data_r;
        pop_s   = 1'b0;
        txd_s   = 1'b1;
        case (state_r)
            ST_IDLE: begin
                baud_s = {CW{1'b0}};
                bit_s  = {BW{1'b0}};
                txd_s  = 1'b1;
                if (can_pop_s) begin
                    pop_s   = 1'b1;
                    data_s  = mem_r[rd_ptr_r];
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                txd_s = 1'b0;
                if (tick_s) begin
                    state_s = ST_DATA;
                    bit_s   = {BW{1'b0}};
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                txd_s = data_r[bit_r];
                if (tick_s && (bit_r == BW'(DATA_BITS - 1))) begin
                    state_s = (PARITY != 0) ? ST_PAR : ST_STOP;
                    bit_s   = {BW{1'b0}};
                end else if (tick_s) begin
                    bit_s = bit_r + 1'b1;
                end else begin
                    bit_s = bit_r;
                end
            end
            ST_PAR: begin
                txd_s = parity_bit(data_r);
                if (tick_s) begin
                    state_s = ST_STOP;
                    bit_s   = {BW{1'b0}};
                end else begin
                    state_s = ST_PAR;
                end
            end
            ST_STOP: begin
                txd_s = 1'b1;
                if (tick_s && (bit_r == BW'(STOP_BITS - 1))) begin
                    bit_s = {BW{1'b0}};
                    if (can_pop_s) begin
                        pop_s   = 1'b1;
                        data_s  = mem_r[rd_ptr_r];
                        state_s = ST_START;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (tick_s) begin
                    bit_s = bit_r + 1'b1;
                end else begin
                    bit_s = bit_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                txd_s   = 1'b1;
            end
        endcase
    end

endmodule
